mux4_rr_arbiter: RTL

Round-robin arbiter and select sequencer for the gate-level 4:1 mux. Four requesters share one output path. The block grants exactly one requester at a time and drives the mux select pair (s1, s2) from the grant. It also muxes the granted requester's data word onto y. A hold-limit counter forces rotation so that no requester starves the others.

---
 rtl/mux4_rr_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_rr_arbiter
//  Purpose  : Round-robin arbiter for four requesters sharing one 4:1 mux
//             path. Drives a registered one-hot grant, the mux select pair
//             and the selected data word. A hold-limit counter forces
//             rotation so that no requester starves the others.
//  Revision : 1.0  initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [3:0]    gnt,
    output logic          s1,
    output logic          s2,
    output logic          valid,
    output logic [DW-1:0] y
);

    localparam int              c_CW        = $clog2(MAX_HOLD);
    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(MAX_HOLD - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_OWNED = 1'b1;

    logic [0:0]      r_state;
    logic [1:0]      r_owner;
    logic [1:0]      r_last;
    logic [c_CW-1:0] r_hold_cnt;
    logic [3:0]      r_gnt;
    logic            r_s1;
    logic            r_s2;
    logic            r_valid;

    logic [1:0]      w_idx;
    logic [1:0]      w_pick;
    logic            w_pick_hit;
    logic [3:0]      w_pick_oh;
    logic [3:0]      w_owner_oh;
    logic [3:0]      w_others;
    logic            w_owner_req;
    logic            w_hold_max;
    logic            w_rotate;

    // Round-robin search: first set request bit starting just after r_last.
    always_comb begin
        w_idx      = 2'd0;
        w_pick     = r_last;
        w_pick_hit = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_pick_hit && req[w_idx]) begin
                w_pick     = w_idx;
                w_pick_hit = 1'b1;
            end
        end
    end

    // Decode of the current owner's situation. Because r_last equals r_owner
    // while owned, the pick can never return the old owner when others wait.
    always_comb begin
        w_pick_oh   = 4'b0001 << w_pick;
        w_owner_oh  = 4'b0001 << r_owner;
        w_others    = req & ~w_owner_oh;
        w_owner_req = req[r_owner];
        w_hold_max  = (r_hold_cnt == c_HOLD_LAST);
        // Release wins over hold expiry; either hands over only if someone waits.
        w_rotate    = (|w_others) && (!w_owner_req || w_hold_max);
    end

    // Arbitration state machine with registered grant/select/valid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_owner    <= 2'd0;
            r_last     <= 2'd3;
            r_hold_cnt <= '0;
            r_gnt      <= 4'b0000;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|req) begin
                        r_state    <= c_OWNED;
                        r_owner    <= w_pick;
                        r_last     <= w_pick;
                        r_hold_cnt <= '0;
                        r_gnt      <= w_pick_oh;
                        r_s1       <= w_pick[0];
                        r_s2       <= w_pick[1];
                        r_valid    <= 1'b1;
                    end
                end
                c_OWNED: begin
                    if (!w_owner_req && !(|w_others)) begin
                        // Everyone gone: drop to idle, priority pointer kept.
                        r_state    <= c_IDLE;
                        r_hold_cnt <= '0;
                        r_gnt      <= 4'b0000;
                        r_s1       <= 1'b0;
                        r_s2       <= 1'b0;
                        r_valid    <= 1'b0;
                    end else if (w_rotate) begin
                        // Direct hand-over with no idle cycle in between.
                        r_owner    <= w_pick;
                        r_last     <= w_pick;
                        r_hold_cnt <= '0;
                        r_gnt      <= w_pick_oh;
                        r_s1       <= w_pick[0];
                        r_s2       <= w_pick[1];
                    end else if (w_hold_max) begin
                        // Sole requester keeps the path; restart its hold window.
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_CW'(1);
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_hold_cnt <= '0;
                    r_gnt      <= 4'b0000;
                    r_s1       <= 1'b0;
                    r_s2       <= 1'b0;
                    r_valid    <= 1'b0;
                end
            endcase
        end
    end

    // Data path: route the granted requester's word, zero when idle.
    always_comb begin
        y = '0;
        if (r_valid) begin
            case ({r_s2, r_s1})
                2'b00:   y = a;
                2'b01:   y = b;
                2'b10:   y = c;
                default: y = d;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign s1    = r_s1;
    assign s2    = r_s2;
    assign valid = r_valid;

endmodule
`default_nettype wire
